// File: rtl/dice_pe_cfg_writer.sv
// Word-serial configuration writer for a DICE PE array: fills per-PE shadow
// registers from a valid/ready stream and publishes them atomically on COMMIT.

module dice_pe_cfg_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        commit,
  input  logic [31:0] wr_opcode,
  input  logic        wr_out_sel,
  input  logic        wr_dff_input_mode,
  input  logic        wr_dff_latch_enable,
  output logic [31:0] opcode,
  output logic        out_sel,
  output logic        dff_input_mode,
  output logic        dff_latch_enable
);
  logic [31:0] sh_opcode;
  logic        sh_out_sel, sh_dim, sh_dle;

  // Shadow writes happen only in OPCODE and commits only in COMMIT, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_opcode        <= '0;
      sh_out_sel       <= 1'b0;
      sh_dim           <= 1'b0;
      sh_dle           <= 1'b0;
      opcode           <= '0;
      out_sel          <= 1'b0;
      dff_input_mode   <= 1'b0;
      dff_latch_enable <= 1'b0;
    end else begin
      if (wr_en) begin
        sh_opcode  <= wr_opcode;
        sh_out_sel <= wr_out_sel;
        sh_dim     <= wr_dff_input_mode;
        sh_dle     <= wr_dff_latch_enable;
      end
      if (commit) begin
        opcode           <= sh_opcode;
        out_sel          <= sh_out_sel;
        dff_input_mode   <= sh_dim;
        dff_latch_enable <= sh_dle;
      end
    end
  end
endmodule

module dice_pe_cfg_writer #(
  parameter int NUM_PE   = 16,
  parameter int PE_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [31:0]            cfg_data,
  input  logic                   cfg_last,
  output logic [NUM_PE*32-1:0]   pe_opcode,
  output logic [NUM_PE-1:0]      pe_out_sel,
  output logic [NUM_PE-1:0]      pe_dff_input_mode,
  output logic [NUM_PE-1:0]      pe_dff_latch_enable,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   busy
);
  typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_DRAIN, S_COMMIT} state_t;
  localparam logic [3:0] CMD_WRITE  = 4'h1;
  localparam logic [3:0] CMD_COMMIT = 4'h2;

  state_t              state, state_d;
  logic [PE_IDX_W-1:0] hold_idx;
  logic                hold_out_sel, hold_dim, hold_dle;
  logic                pend;
  logic                xfer, idx_ok;
  logic                latch_hdr, wr_en, err_set, pend_set, pend_clr, commit;
  logic [3:0]          cmd;
  logic [PE_IDX_W-1:0] hdr_idx;
  logic                unused_bits;

  assign cfg_ready   = !rst && (state != S_COMMIT);
  assign busy        = (state != S_IDLE);
  assign xfer        = cfg_valid && cfg_ready;
  assign cmd         = cfg_data[31:28];
  assign hdr_idx     = cfg_data[PE_IDX_W-1:0];
  assign idx_ok      = (32'(hdr_idx) < NUM_PE);
  assign unused_bits = ^{cfg_data[27:19], cfg_data[15:PE_IDX_W]};

  always_comb begin
    state_d   = state;
    latch_hdr = 1'b0;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: if (xfer) begin
        case (cmd)
          CMD_WRITE:
            if (cfg_last) err_set = 1'b1;
            else if (idx_ok) begin
              latch_hdr = 1'b1;
              state_d   = S_OPCODE;
            end else begin
              err_set = 1'b1;
              state_d = S_DRAIN;
            end
          CMD_COMMIT:
            if (cfg_last) state_d = S_COMMIT;
            else begin
              pend_set = 1'b1;
              err_set  = 1'b1;
              state_d  = S_DRAIN;
            end
          default: begin
            err_set = 1'b1;
            if (!cfg_last) state_d = S_DRAIN;
          end
        endcase
      end
      // Opcode word is written even when the packet is malformed (last=0).
      S_OPCODE: if (xfer) begin
        wr_en = 1'b1;
        if (cfg_last) state_d = S_IDLE;
        else begin
          err_set = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (xfer && cfg_last) begin
        pend_clr = 1'b1;
        state_d  = pend ? S_COMMIT : S_IDLE;
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_idx     <= '0;
      hold_out_sel <= 1'b0;
      hold_dim     <= 1'b0;
      hold_dle     <= 1'b0;
      pend         <= 1'b0;
      cfg_err      <= 1'b0;
      cfg_done     <= 1'b0;
    end else begin
      if (latch_hdr) begin
        hold_idx     <= hdr_idx;
        hold_out_sel <= cfg_data[16];
        hold_dim     <= cfg_data[17];
        hold_dle     <= cfg_data[18];
      end
      if (pend_set)      pend <= 1'b1;
      else if (pend_clr) pend <= 1'b0;
      if (commit)        cfg_err <= 1'b0;
      else if (err_set)  cfg_err <= 1'b1;
      cfg_done <= commit;
    end
  end

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
    dice_pe_cfg_slot u_slot (
      .clk                 (clk),
      .rst                 (rst),
      .wr_en               (wr_en && (hold_idx == PE_IDX_W'(gi))),
      .commit              (commit),
      .wr_opcode           (cfg_data),
      .wr_out_sel          (hold_out_sel),
      .wr_dff_input_mode   (hold_dim),
      .wr_dff_latch_enable (hold_dle),
      .opcode              (pe_opcode[32*gi +: 32]),
      .out_sel             (pe_out_sel[gi]),
      .dff_input_mode      (pe_dff_input_mode[gi]),
      .dff_latch_enable    (pe_dff_latch_enable[gi])
    );
  end
endmodule

// File: tb/tb_dice_pe_cfg_writer.sv
// Directed bench for dice_pe_cfg_writer: shadow/commit behaviour, error paths,
// mid-packet reset and a gapped random stream against a small reference model.

module tb_dice_pe_cfg_writer;
  localparam int NUM_PE = 16;

  logic                   clk, rst;
  logic                   cfg_valid, cfg_ready, cfg_last;
  logic [31:0]            cfg_data;
  logic [NUM_PE*32-1:0]   pe_opcode;
  logic [NUM_PE-1:0]      pe_out_sel, pe_dff_input_mode, pe_dff_latch_enable;
  logic                   cfg_done, cfg_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_PE*32-1:0] exp_op;
  logic [NUM_PE-1:0]    exp_os, exp_dim, exp_dle;

  // Index field widened by one bit so that index 16 is representable and rejected.
  dice_pe_cfg_writer #(.NUM_PE(NUM_PE), .PE_IDX_W(5)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .pe_opcode(pe_opcode),
    .pe_out_sel(pe_out_sel), .pe_dff_input_mode(pe_dff_input_mode),
    .pe_dff_latch_enable(pe_dff_latch_enable), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [31:0] d, input logic l);
    int guard = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_data = d; cfg_last = l;
    while (!cfg_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cfg_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: cfg_ready=%b required 1 for word %h", cfg_ready, d);
    end
    @(posedge clk);
  endtask

  task automatic idle_neg();
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic gap();
    if ($urandom_range(0, 1) == 1) idle_neg();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (pe_opcode !== '0) begin n_fail++; $display("FAIL reset_opcode: got %h want 0", pe_opcode); end
    n_checks++; if ({cfg_done, cfg_err, pe_out_sel, pe_dff_input_mode, pe_dff_latch_enable} !== '0) begin
      n_fail++; $display("FAIL reset_flags: done=%b err=%b os=%h dim=%h dle=%h want all 0",
                         cfg_done, cfg_err, pe_out_sel, pe_dff_input_mode, pe_dff_latch_enable);
    end
    rst = 1'b0;
    exp_op = '0; exp_os = '0; exp_dim = '0; exp_dle = '0;
  endtask

  task automatic test_write_commit();
    int pulses = 0;
    send(32'h1007_0003, 1'b0);
    send(32'hDEAD_BEEF, 1'b1);
    idle_neg();
    n_checks++; if (pe_opcode !== '0 || pe_out_sel !== '0) begin
      n_fail++; $display("FAIL precommit_hidden: op=%h os=%h want 0", pe_opcode, pe_out_sel);
    end
    send(32'h2000_0000, 1'b1);
    idle_neg();
    n_checks++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL commit_state: ready=%b busy=%b want 0/1", cfg_ready, busy);
    end
    if (cfg_done) pulses++;
    idle_neg();
    exp_op[127:96] = 32'hDEAD_BEEF; exp_os[3] = 1'b1; exp_dim[3] = 1'b1; exp_dle[3] = 1'b1;
    n_checks++; if (pe_opcode[127:96] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL pe3_opcode: got %h want deadbeef", pe_opcode[127:96]);
    end
    n_checks++; if ({pe_out_sel[3], pe_dff_input_mode[3], pe_dff_latch_enable[3]} !== 3'b111) begin
      n_fail++; $display("FAIL pe3_bits: got %b%b%b want 111", pe_out_sel[3], pe_dff_input_mode[3], pe_dff_latch_enable[3]);
    end
    if (cfg_done) pulses++;
    repeat (3) begin idle_neg(); if (cfg_done) pulses++; end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL done_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_last_wins();
    send(32'h1000_0000, 1'b0);
    send(32'h0000_0011, 1'b1);
    send(32'h1000_0000, 1'b0);
    send(32'h0000_0022, 1'b1);
    send(32'h2000_0000, 1'b1);
    // Offer a word during COMMIT; it must not be taken.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_data = 32'h1001_0005; cfg_last = 1'b1;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL commit_ready_valid: got %b want 0", cfg_ready); end
    idle_neg();
    exp_op[31:0] = 32'h22;
    n_checks++; if (pe_opcode !== exp_op) begin n_fail++; $display("FAIL last_wins: got %h want %h", pe_opcode, exp_op); end
    n_checks++; if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL last_wins_flags: done=%b err=%b want 1/0", cfg_done, cfg_err);
    end
  endtask

  task automatic test_bad_index();
    send(32'h1000_0010, 1'b0);
    idle_neg();
    n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bad_idx_err: err=%b busy=%b want 1/1", cfg_err, busy);
    end
    send(32'h1234_5678, 1'b1);
    idle_neg();
    n_checks++; if (busy !== 1'b0 || cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL bad_idx_drained: busy=%b err=%b want 0/1", busy, cfg_err);
    end
    send(32'h2000_0000, 1'b1);
    idle_neg(); idle_neg();
    n_checks++; if (pe_opcode !== exp_op || pe_out_sel !== exp_os) begin
      n_fail++; $display("FAIL bad_idx_unchanged: op=%h os=%h want %h %h", pe_opcode, pe_out_sel, exp_op, exp_os);
    end
    n_checks++; if (cfg_err !== 1'b0 || cfg_done !== 1'b1) begin
      n_fail++; $display("FAIL bad_idx_commit: err=%b done=%b want 0/1", cfg_err, cfg_done);
    end
  endtask

  task automatic test_commit_drain();
    send(32'h1001_0005, 1'b0);
    send(32'h0000_0055, 1'b1);
    send(32'h2000_0000, 1'b0);
    idle_neg();
    n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL drain_err: err=%b busy=%b want 1/1", cfg_err, busy);
    end
    send(32'hAAAA_AAAA, 1'b0);
    send(32'h5555_5555, 1'b1);
    idle_neg();
    n_checks++; if (cfg_ready !== 1'b0 || cfg_err !== 1'b1 || pe_opcode !== exp_op) begin
      n_fail++; $display("FAIL drain_commit_cycle: ready=%b err=%b want 0/1 op=%h", cfg_ready, cfg_err, pe_opcode);
    end
    idle_neg();
    exp_op[191:160] = 32'h55; exp_os[5] = 1'b1;
    n_checks++; if (pe_opcode !== exp_op || pe_out_sel !== exp_os || pe_dff_input_mode !== exp_dim) begin
      n_fail++; $display("FAIL drain_commit_effect: op=%h os=%h want %h %h", pe_opcode, pe_out_sel, exp_op, exp_os);
    end
    n_checks++; if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL drain_commit_flags: done=%b err=%b want 1/0", cfg_done, cfg_err);
    end
  endtask

  task automatic test_reset_mid();
    send(32'h1007_0002, 1'b0);
    @(negedge clk);
    cfg_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || pe_opcode !== '0 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_clear: busy=%b err=%b op=%h want 0", busy, cfg_err, pe_opcode);
    end
    send(32'h1000_0001, 1'b0);
    send(32'h0000_0005, 1'b1);
    send(32'h2000_0000, 1'b1);
    idle_neg(); idle_neg();
    exp_op = '0; exp_op[63:32] = 32'h5; exp_os = '0; exp_dim = '0; exp_dle = '0;
    n_checks++; if (pe_opcode !== exp_op) begin n_fail++; $display("FAIL mid_reset_op: got %h want %h", pe_opcode, exp_op); end
    n_checks++; if ({pe_out_sel, pe_dff_input_mode, pe_dff_latch_enable} !== '0) begin
      n_fail++; $display("FAIL mid_reset_bits: os=%h dim=%h dle=%h want 0", pe_out_sel, pe_dff_input_mode, pe_dff_latch_enable);
    end
  endtask

  task automatic test_random_gaps();
    logic [31:0] op;
    logic [2:0]  b;
    logic [3:0]  idx;
    // Shadow equals active after the previous commit, so the model starts from exp_*.
    for (int k = 0; k < 64; k++) begin
      idx = 4'($urandom_range(0, NUM_PE - 1));
      b   = 3'($urandom_range(0, 7));
      op  = $urandom;
      gap(); send(32'h1000_0000 | (32'(b) << 16) | 32'(idx), 1'b0);
      gap(); send(op, 1'b1);
      exp_op[32*idx +: 32] = op;
      exp_os[idx] = b[0]; exp_dim[idx] = b[1]; exp_dle[idx] = b[2];
    end
    idle_neg();
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b want 0", cfg_err); end
    gap(); send(32'h2000_0000, 1'b1);
    idle_neg(); idle_neg();
    n_checks++; if (pe_opcode !== exp_op) begin n_fail++; $display("FAIL rand_opcode: got %h want %h", pe_opcode, exp_op); end
    n_checks++; if (pe_out_sel !== exp_os) begin n_fail++; $display("FAIL rand_out_sel: got %h want %h", pe_out_sel, exp_os); end
    n_checks++; if (pe_dff_input_mode !== exp_dim) begin n_fail++; $display("FAIL rand_dim: got %h want %h", pe_dff_input_mode, exp_dim); end
    n_checks++; if (pe_dff_latch_enable !== exp_dle) begin n_fail++; $display("FAIL rand_dle: got %h want %h", pe_dff_latch_enable, exp_dle); end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_last_wins();
    test_bad_index();
    test_commit_drain();
    test_reset_mid();
    test_random_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dice_pe_cfg_writer.md
# dice_pe_cfg_writer

Configuration writer that drives the static and dynamic configuration inputs of an array of DICE PEs. It accepts a word-serial configuration stream over a valid/ready handshake and writes per-PE `opcode`, `out_sel`, `dff_input_mode` and `dff_latch_enable` into shadow registers. On a COMMIT command it copies all shadow values to the active outputs in one cycle, so the PE array never sees a partially updated configuration. It sits between the CGRA configuration fetch path and the PE array.

## Interface
Parameters:
- `NUM_PE`, default 16: number of PEs driven, 1..256.
- `PE_IDX_W`, default `$clog2(NUM_PE)` (minimum 1): width of the PE index field.

Ports:
- `clk`  in  1  clock. One clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_valid`  in  1  stream word valid.
- `cfg_ready`  out  1  stream word accept.
- `cfg_data`  in  32  stream word.
- `cfg_last`  in  1  last word of packet.
- `pe_opcode`  out  NUM_PE*32  active opcodes; PE i uses bits [32*i+31:32*i].
- `pe_out_sel`  out  NUM_PE  active `out_sel`, bit i for PE i.
- `pe_dff_input_mode`  out  NUM_PE  active `dff_input_mode`.
- `pe_dff_latch_enable`  out  NUM_PE  active `dff_latch_enable`.
- `cfg_done`  out  1  one-cycle pulse when a commit takes effect.
- `cfg_err`  out  1  sticky error flag; cleared by reset or by a commit.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- Handshake: a word transfers on a cycle with `cfg_valid && cfg_ready`. `cfg_data` and `cfg_last` are sampled only on a transfer.
- Header word layout:
  - [31:28] cmd.
  - [PE_IDX_W-1:0] PE index.
  - bit 16: out_sel.
  - bit 17: dff_input_mode.
  - bit 18: dff_latch_enable.
  - All other bits are ignored.
- cmd 4'h1 WRITE_PE: two-word packet, header then opcode word.
- cmd 4'h2 COMMIT: one-word packet.
- Any other cmd is illegal: set `cfg_err`, then drain.
- States:
  - IDLE: wait for a header.
    - WRITE_PE with last=0 and index < NUM_PE: latch the header fields into a holding register, go to OPCODE.
    - WRITE_PE with last=1: set `cfg_err`; no shadow write; stay in IDLE.
    - WRITE_PE with index ≥ NUM_PE and last=0: set `cfg_err`, go to DRAIN. With last=1: set `cfg_err`, stay in IDLE.
    - COMMIT with last=1: go to COMMIT.
    - COMMIT with last=0: go to DRAIN with a pending-commit flag set, and set `cfg_err`.
    - Illegal cmd: last=0 goes to DRAIN; last=1 stays in IDLE.
  - OPCODE: on transfer, write the opcode plus the held fields into shadow[index].
    - last=1: go to IDLE.
    - last=0: set `cfg_err`, go to DRAIN. The shadow write still happens.
  - DRAIN: discard words until a transfer with last=1. Then go to COMMIT if the pending-commit flag is set, otherwise to IDLE.
  - COMMIT: one cycle with `cfg_ready`=0. All active registers load from shadow, `cfg_err` clears, then go to IDLE.
- `cfg_ready` = !rst && state ≠ COMMIT.
- Shadow registers are never visible at the outputs until a commit.
- Rewriting the same PE before a commit: the last write wins.
- Reset mid-packet: state goes to IDLE. Shadow, active, pending-commit flag and holding register all clear to 0; the partial packet is discarded. The upstream source must restart from a header.

## Timing
- Reset values: all `pe_*` outputs 0, `cfg_done`=0, `cfg_err`=0, `busy`=0, `cfg_ready`=0 while `rst` is high.
- WRITE_PE: header accepted at cycle N, opcode word at N+1 at the earliest. The shadow register is updated at the edge ending the opcode transfer.
- COMMIT latency: last word of the commit packet accepted at cycle N.
  - State is COMMIT during N+1 (`cfg_ready`=0, `busy`=1).
  - New `pe_*` values, `cfg_done`=1 and `cfg_err`=0 are visible during N+2.
  - `cfg_done` is high for exactly one cycle.
- Gaps (`cfg_valid`=0) are allowed in any state except COMMIT; state is held across them.
- All outputs are registered; there is no combinational path from `cfg_*` inputs to `pe_*` outputs.
- `cfg_ready` depends only on state and `rst`, never on `cfg_valid`.

## Test plan
- Reset, then WRITE_PE to PE 3 (header 0x1007_0003, opcode 0xDEAD_BEEF, last on word 2) followed by COMMIT 0x2000_0000:
  - Before the commit, all outputs are 0.
  - Two cycles after the commit transfer, `pe_opcode[127:96]`=0xDEADBEEF and bits 3 of `pe_out_sel`, `pe_dff_input_mode` and `pe_dff_latch_enable` are 1.
  - `cfg_done` pulses once.
- Two writes to PE 0 (opcodes 0x11, then 0x22), then commit: `pe_opcode[31:0]`=0x22. During the COMMIT cycle `cfg_ready`=0 even with `cfg_valid`=1.
- Index 16 with NUM_PE=16 (header 0x1000_0010, one extra word, last): `cfg_err`=1, no shadow change. A following commit leaves outputs unchanged and clears `cfg_err`.
- Commit with last=0 followed by 2 junk words, the last one flagged last:
  - Junk is drained and `cfg_err` goes to 1.
  - Commit takes effect two cycles after the final junk transfer; `cfg_err` is 0 from then.
- Assert `rst` for 1 cycle between a WRITE_PE header and its opcode word, then send a fresh WRITE_PE (PE 1, opcode 0x5) and a commit: only PE 1 is configured, and `busy`=0 right after reset.
- Random `cfg_valid` gaps (~50% duty) over 64 WRITE_PE packets plus a commit: active state matches a reference model, and no word is lost or duplicated.
